sample_ring: RTL
================

SAMPLE_RING -- requirements
Module: sample_ring

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning log2 of buffer depth (depth = 2**ADDR_W entries).
REQ-003 SHALL have parameter CHAN_W, default 2, meaning width of the channel tag stored with each sample.
REQ-004 SHALL have parameter OVERWRITE, default 0, meaning full-buffer policy: 0 = drop newest, 1 = overwrite oldest.
REQ-005 SHALL have port ck, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, meaning a write request this cycle.
REQ-008 SHALL have port in_data, input, WIDTH, meaning the sample to store.
REQ-009 SHALL have port in_chan, input, CHAN_W, meaning the channel tag to store with the sample.
REQ-010 SHALL have port rd_req, input, 1, meaning a pop request this cycle.
REQ-011 SHALL have port rd_valid, output, 1, meaning rd_data and rd_chan are valid this cycle.
REQ-012 SHALL have port rd_data, output, WIDTH, meaning the popped sample.
REQ-013 SHALL have port rd_chan, output, CHAN_W, meaning the popped channel tag.
REQ-014 SHALL have port level, output, ADDR_W+1, meaning the current entry count, 0..2**ADDR_W.
REQ-015 SHALL have ports empty and full, output, 1 each, meaning level==0 and level==2**ADDR_W respectively.
REQ-016 SHALL have port ovf_count, output, 16, meaning dropped or overwritten samples, saturating at 0xFFFF.
REQ-017 SHALL have port underflow, output, 1, meaning a sticky flag set by rd_req while empty.
REQ-018 SHALL have port clr, input, 1, meaning a synchronous clear of ovf_count and underflow only.

Function
REQ-019 SHALL accept a write on any rising ck edge with in_valid=1, storing {in_chan,in_data} at wptr and incrementing wptr modulo 2**ADDR_W, except as stated in REQ-023.
REQ-020 SHALL treat rd_req with empty=0 as a pop: read at rptr, increment rptr modulo depth, assert rd_valid on the next cycle with the data; read latency is exactly 1 cycle.
REQ-021 SHALL hold rd_data/rd_chan at their last value when rd_valid=0; rd_valid is a one-cycle pulse per pop.
REQ-022 SHALL update level, empty and full one cycle after the accepting edge: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-023 SHALL, when full, in_valid=1 and rd_req=0: if OVERWRITE=0, discard the sample and leave wptr unchanged; if OVERWRITE=1, write at wptr, advance both wptr and rptr, and leave level at full. In both cases ovf_count increments by 1 (saturating).
REQ-024 SHALL, when full with in_valid=1 and rd_req=1, perform both the pop (returning the oldest entry) and the write, with no ovf_count change.
REQ-025 SHALL, when empty with in_valid=1 and rd_req=1, perform the write only, provide no bypass, keep rd_valid=0, and set underflow.
REQ-026 SHALL, on rd_req while empty, set underflow and leave pointers unchanged.
REQ-027 SHALL give clr priority over a same-cycle increment: ovf_count=0 and underflow=0 on the next cycle.
REQ-028 SHALL track full/empty with ADDR_W+1-bit pointers, where the extra bit indicates wrap; no entry is sacrificed.

Reset
REQ-029 SHALL, while rst_n=0, immediately force wptr=rptr=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_chan=0, ovf_count=0 and underflow=0.
REQ-030 SHALL leave RAM contents unreset; a reset mid-operation discards all queued samples and any pending rd_valid.
REQ-031 SHALL ignore in_valid and rd_req on the first edge after rst_n deasserts only if that edge is within the same cycle as deassertion; otherwise it operates normally.

Structure
REQ-032 SHALL place the overwrite-policy constants (DROP_NEWEST=0, OVERWRITE_OLDEST=1) and the default widths in package sample_ring_pkg.
REQ-033 SHALL instantiate a single sub-module sample_ring_ram: a simple dual-port RAM with one clock, WIDTH+CHAN_W bits by 2**ADDR_W words, a registered read and no reset, inferable as block RAM.

Verification
REQ-034 SHALL verify: write samples 0x0001..0x0004 on channels 0..3, then pop 4 times -> rd_valid one cycle after each rd_req, data in order, level 4->0, empty=1.
REQ-035 SHALL verify: ADDR_W=3, OVERWRITE=0, write 10 samples 0x10..0x19 -> full after 8, ovf_count=2, pops return 0x10..0x17.
REQ-036 SHALL verify: ADDR_W=3, OVERWRITE=1, write 10 samples 0x10..0x19 -> ovf_count=2, level=8, pops return 0x12..0x19.
REQ-037 SHALL verify: when full, apply in_valid and rd_req together -> oldest returned, level stays 8, ovf_count unchanged.
REQ-038 SHALL verify: rd_req on an empty buffer -> rd_valid=0 and underflow=1; then clr -> underflow=0 and ovf_count=0 next cycle.
REQ-039 SHALL verify: assert rst_n=0 with level=5 and rd_valid=1 -> all outputs reach reset values without a clock edge; after release, a pop yields nothing until a new write.

Source files
------------

// File: rtl/sample_ring_pkg.sv
// Shared constants for the sample ring buffer: full-buffer policies and default widths.
package sample_ring_pkg;
    localparam int DROP_NEWEST      = 0;
    localparam int OVERWRITE_OLDEST = 1;
    localparam int DEF_WIDTH        = 16;
    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_CHAN_W       = 2;
    localparam int OVF_W            = 16;
endpackage

// File: rtl/sample_ring_ram.sv
// Simple dual-port RAM, one clock, registered read, no reset (block-RAM inferable).
module sample_ring_ram
    import sample_ring_pkg::*;
#(
    parameter int DW = DEF_WIDTH + DEF_CHAN_W,
    parameter int AW = DEF_ADDR_W
) (
    input  logic          ck,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Read returns the pre-write contents when both ports hit the same word.
    always_ff @(posedge ck) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_ring.sv
// Circular sample buffer with channel tags, 1-cycle pop latency, selectable
// full-buffer policy, saturating overflow counter and sticky underflow flag.
module sample_ring
    import sample_ring_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CHAN_W    = DEF_CHAN_W,
    parameter int OVERWRITE = DROP_NEWEST
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CHAN_W-1:0] in_chan,
    input  logic              rd_req,
    input  logic              clr,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic [CHAN_W-1:0] rd_chan,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic [OVF_W-1:0]  ovf_count,
    output logic              underflow
);

    localparam int EW = WIDTH + CHAN_W;
    localparam bit OVW = (OVERWRITE == OVERWRITE_OLDEST);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == {OVF_W{1'b1}}) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
    endfunction

    logic [ADDR_W:0] wptr_p0, rptr_p0;
    logic            do_pop, do_wr, ovf_evt, adv_r;
    logic            vld_p1, hold_p1;
    logic [EW-1:0]   q_p1;

    // Stage p0: pointer arithmetic and request qualification
    always_comb begin
        level   = wptr_p0 - rptr_p0;
        empty   = (level == '0);
        full    = level[ADDR_W];
        do_pop  = rd_req & ~empty;
        ovf_evt = in_valid & full & ~rd_req;
        do_wr   = in_valid & (~ovf_evt | OVW);
        adv_r   = do_pop | (ovf_evt & OVW);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wptr_p0   <= '0;
            rptr_p0   <= '0;
            vld_p1    <= 1'b0;
            hold_p1   <= 1'b0;
            ovf_count <= '0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wptr_p0 <= wptr_p0 + PTR_ONE;
            if (adv_r) rptr_p0 <= rptr_p0 + PTR_ONE;
            vld_p1 <= do_pop;
            if (do_pop) hold_p1 <= 1'b1;
            if (clr) begin
                ovf_count <= '0;
                underflow <= 1'b0;
            end else begin
                if (ovf_evt) ovf_count <= sat_inc(ovf_count);
                if (rd_req && empty) underflow <= 1'b1;
            end
        end
    end

    sample_ring_ram #(
        .DW (EW),
        .AW (ADDR_W)
    ) u_ram (
        .ck    (ck),
        .we    (do_wr),
        .waddr (wptr_p0[ADDR_W-1:0]),
        .wdata ({in_chan, in_data}),
        .re    (do_pop),
        .raddr (rptr_p0[ADDR_W-1:0]),
        .rdata (q_p1)
    );

    // Stage p1: RAM word presented; zero until the first pop since reset
    always_comb begin
        rd_valid = vld_p1;
        rd_data  = hold_p1 ? q_p1[WIDTH-1:0] : '0;
        rd_chan  = hold_p1 ? q_p1[EW-1:WIDTH] : '0;
    end

endmodule
